// File: rtl/debug_io_pkg.sv
// Shared types and index helpers for the board-side debug write path.
// Used by debug_word_writer; autoincrement is enabled with DEBUG_WRITER_AUTOINC_EN.
package debug_io_pkg;

    localparam int unsigned IDX_W       = 10;
    localparam int unsigned INSTR_DEPTH = 256;
    localparam int unsigned REG_DEPTH   = 32;
    localparam int unsigned HILO_DEPTH  = 2;
    localparam int unsigned MEM_DEPTH   = 1024;

    typedef enum logic [1:0] {
        TGT_INSTR = 2'd0,
        TGT_REG   = 2'd1,
        TGT_HILO  = 2'd2,
        TGT_MEM   = 2'd3
    } target_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOW_OK = 2'd1,
        ST_READY  = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    // Out-of-range indices wrap to the target depth rather than erroring.
    function automatic logic [IDX_W-1:0] mask_index(input target_t tgt, input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] m;
        case (tgt)
            TGT_INSTR: m = IDX_W'(INSTR_DEPTH - 1);
            TGT_REG:   m = IDX_W'(REG_DEPTH - 1);
            TGT_HILO:  m = IDX_W'(HILO_DEPTH - 1);
            default:   m = IDX_W'(MEM_DEPTH - 1);
        endcase
        return idx & m;
    endfunction

    // Register 0 is not writable, so register streaming wraps 31 -> 1.
    function automatic logic [IDX_W-1:0] next_index(input target_t tgt, input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] n;
        n = mask_index(tgt, idx + IDX_W'(1));
        if (tgt == TGT_REG && n == '0) begin
            n = IDX_W'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Synchronises one raw push-button and emits a registered one-cycle pulse per press.
module key_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_key,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_key};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/debug_word_writer.sv
// Assembles a word from switches in two halves and commits it to a debug target.
// Define DEBUG_WRITER_AUTOINC_EN to advance the index after each successful write.
module debug_word_writer
    import debug_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W/2-1:0] switches,
    input  logic                keyLoadLow,
    input  logic                keyLoadHigh,
    input  logic                keyCommit,
    input  logic [1:0]          select,
    input  logic [ADDR_W-1:0]   derreference,
    output logic [DATA_W-1:0]   writeData,
    output logic [ADDR_W-1:0]   writeAddress,
    output logic                instrWe,
    output logic                regWe,
    output logic                hiLoWe,
    output logic                memWe,
    output logic                ready,
    output logic                writeError
);

    localparam int unsigned HALF_W = DATA_W / 2;

    logic w_ev_low;
    logic w_ev_high;
    logic w_ev_commit;

    key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_low (
        .clock(clock), .reset(reset), .i_key(keyLoadLow), .o_pulse(w_ev_low));
    key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_high (
        .clock(clock), .reset(reset), .i_key(keyLoadHigh), .o_pulse(w_ev_high));
    key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_commit (
        .clock(clock), .reset(reset), .i_key(keyCommit), .o_pulse(w_ev_commit));

    state_t              r_state,  w_nxt_state;
    logic [DATA_W-1:0]   r_data,   w_nxt_data;
    logic [ADDR_W-1:0]   r_addr,   w_nxt_addr;
    target_t             r_target, w_nxt_target;
    logic [3:0]          r_we,     w_nxt_we;
    logic                r_ready,  w_nxt_ready;
    logic                r_error,  w_nxt_error;
    logic                r_auto,   w_nxt_auto;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_data   <= '0;
            r_addr   <= '0;
            r_target <= TGT_INSTR;
            r_we     <= '0;
            r_ready  <= 1'b0;
            r_error  <= 1'b0;
            r_auto   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_data   <= w_nxt_data;
            r_addr   <= w_nxt_addr;
            r_target <= w_nxt_target;
            r_we     <= w_nxt_we;
            r_ready  <= w_nxt_ready;
            r_error  <= w_nxt_error;
            r_auto   <= w_nxt_auto;
        end
    end

    // Event priority within a state is loadLow > loadHigh > commit.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_data   = r_data;
        w_nxt_addr   = r_addr;
        w_nxt_target = r_target;
        w_nxt_we     = '0;
        w_nxt_error  = r_error;
        w_nxt_auto   = r_auto;

        case (r_state)
            ST_IDLE: begin
                if (w_ev_low) begin
                    w_nxt_data[HALF_W-1:0] = switches;
                    w_nxt_target           = target_t'(select);
                    w_nxt_addr             = ADDR_W'(mask_index(target_t'(select), IDX_W'(derreference)));
                    w_nxt_state            = ST_LOW_OK;
                end else if (w_ev_high && r_auto) begin
                    w_nxt_data[DATA_W-1:HALF_W] = switches;
                    w_nxt_state                 = ST_READY;
                end
            end
            ST_LOW_OK: begin
                if (w_ev_low) begin
                    w_nxt_data[HALF_W-1:0] = switches;
                    w_nxt_target           = target_t'(select);
                    w_nxt_addr             = ADDR_W'(mask_index(target_t'(select), IDX_W'(derreference)));
                end else if (w_ev_high) begin
                    w_nxt_data[DATA_W-1:HALF_W] = switches;
                    w_nxt_state                 = ST_READY;
                end
            end
            ST_READY: begin
                if (w_ev_low) begin
                    w_nxt_data[HALF_W-1:0] = switches;
                    w_nxt_target           = target_t'(select);
                    w_nxt_addr             = ADDR_W'(mask_index(target_t'(select), IDX_W'(derreference)));
                    w_nxt_state            = ST_LOW_OK;
                end else if (w_ev_high) begin
                    w_nxt_data[DATA_W-1:HALF_W] = switches;
                end else if (w_ev_commit) begin
                    w_nxt_state = ST_WRITE;
                    if (r_target == TGT_REG && r_addr == '0) begin
                        w_nxt_error = 1'b1;
                    end else begin
                        w_nxt_we    = 4'(4'b0001 << r_target);
                        w_nxt_error = 1'b0;
                    end
                end
            end
            ST_WRITE: begin
                w_nxt_state = ST_IDLE;
`ifdef DEBUG_WRITER_AUTOINC_EN
                // r_error already reflects this commit's outcome.
                if (!r_error) begin
                    w_nxt_addr = ADDR_W'(next_index(r_target, IDX_W'(r_addr)));
                    w_nxt_auto = 1'b1;
                end else begin
                    w_nxt_auto = 1'b0;
                end
`else
                w_nxt_auto = 1'b0;
`endif
            end
            default: w_nxt_state = ST_IDLE;
        endcase

        w_nxt_ready = (w_nxt_state == ST_READY);
    end

    assign writeData    = r_data;
    assign writeAddress = r_addr;
    assign instrWe      = r_we[0];
    assign regWe        = r_we[1];
    assign hiLoWe       = r_we[2];
    assign memWe        = r_we[3];
    assign ready        = r_ready;
    assign writeError   = r_error;

endmodule

// File: tb/tb_debug_word_writer.sv
// Scoreboard bench for debug_word_writer; covers the autoincrement mode when DEBUG_WRITER_AUTOINC_EN is defined.
module tb_debug_word_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] switches = '0;
    logic        keyLoadLow = 1'b0;
    logic        keyLoadHigh = 1'b0;
    logic        keyCommit = 1'b0;
    logic [1:0]  select = '0;
    logic [9:0]  derreference = '0;
    logic [31:0] writeData;
    logic [9:0]  writeAddress;
    logic        instrWe, regWe, hiLoWe, memWe, ready, writeError;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] data;
        logic [9:0]  addr;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   errors = 0;
    int   checks = 0;
    int   strobe_cnt = 0;
    logic [3:0] prev_w = '0;
    logic [3:0] cur_w;

    debug_word_writer dut (
        .clock(clock), .reset(reset), .switches(switches),
        .keyLoadLow(keyLoadLow), .keyLoadHigh(keyLoadHigh), .keyCommit(keyCommit),
        .select(select), .derreference(derreference),
        .writeData(writeData), .writeAddress(writeAddress),
        .instrWe(instrWe), .regWe(regWe), .hiLoWe(hiLoWe), .memWe(memWe),
        .ready(ready), .writeError(writeError));

    always #5 clock = ~clock;

    // Strobe monitor: every strobe cycle must match the oldest expected write.
    always @(negedge clock) begin
        cur_w = {memWe, hiLoWe, regWe, instrWe};
        if (cur_w != 4'b0) begin
            strobe_cnt++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe we=%b data=%h addr=%h", cur_w, writeData, writeAddress);
            end else begin
                e_mon = q.pop_front();
                if ({cur_w, writeData, writeAddress} !== e_mon) begin
                    errors++;
                    $display("FAIL strobe_payload got we=%b data=%h addr=%h exp we=%b data=%h addr=%h",
                             cur_w, writeData, writeAddress, e_mon.we, e_mon.data, e_mon.addr);
                end
            end
            checks++;
            if (prev_w !== 4'b0) begin
                errors++;
                $display("FAIL strobe_width prev=%b cur=%b exp prev=0000", prev_w, cur_w);
            end
        end
        prev_w = cur_w;
    end

    task automatic press(input logic [2:0] keys, input int hold);
        @(negedge clock);
        {keyCommit, keyLoadHigh, keyLoadLow} = keys;
        repeat (hold) @(negedge clock);
        {keyCommit, keyLoadHigh, keyLoadLow} = 3'b000;
        repeat (8) @(negedge clock);
    endtask

    task automatic load_word(input logic [1:0] sel, input logic [9:0] idx,
                             input logic [15:0] lo, input logic [15:0] hi);
        select = sel;
        derreference = idx;
        switches = lo;
        press(3'b001, 1);
        switches = hi;
        press(3'b010, 1);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({writeData, writeAddress} !== 42'b0) begin
            errors++;
            $display("FAIL reset_data_addr got data=%h addr=%h exp 0", writeData, writeAddress);
        end
        checks++;
        if ({instrWe, regWe, hiLoWe, memWe, ready, writeError} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000", {instrWe, regWe, hiLoWe, memWe, ready, writeError});
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_idle_ignore;
        int s;
        s = strobe_cnt;
        switches = 16'h7777;
        press(3'b010, 1);
        press(3'b100, 1);
        checks++;
        if (ready !== 1'b0 || strobe_cnt != s || writeData !== 32'h0) begin
            errors++;
            $display("FAIL idle_ignore got ready=%b strobes=%0d data=%h exp ready=0 strobes=%0d data=0",
                     ready, strobe_cnt, writeData, s);
        end
    endtask

    task automatic test_mem_write;
        load_word(2'd3, 10'h3FF, 16'hBEEF, 16'hDEAD);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL mem_ready got %b exp 1", ready);
        end
        q.push_back('{we: 4'b1000, data: 32'hDEADBEEF, addr: 10'h3FF});
        press(3'b100, 1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL mem_strobe_missing pending=%0d exp 0", q.size());
        end
        checks++;
        if (ready !== 1'b0 || writeError !== 1'b0) begin
            errors++;
            $display("FAIL mem_after got ready=%b err=%b exp 0 0", ready, writeError);
        end
        checks++;
`ifdef DEBUG_WRITER_AUTOINC_EN
        if (writeAddress !== 10'h000) begin
            errors++;
            $display("FAIL mem_addr_after got %h exp 000", writeAddress);
        end
`else
        if (writeAddress !== 10'h3FF) begin
            errors++;
            $display("FAIL mem_addr_after got %h exp 3ff", writeAddress);
        end
`endif
    endtask

    task automatic test_instr_mask;
        select = 2'd0;
        derreference = 10'h1A5;
        switches = 16'h1234;
        press(3'b001, 1);
        checks++;
        if (writeAddress !== 10'h0A5) begin
            errors++;
            $display("FAIL instr_mask got %h exp 0a5", writeAddress);
        end
        switches = 16'h5678;
        press(3'b010, 1);
        q.push_back('{we: 4'b0001, data: 32'h56781234, addr: 10'h0A5});
        press(3'b100, 1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL instr_strobe_missing pending=%0d exp 0", q.size());
        end
        select = 2'd2;
        derreference = 10'h003;
        switches = 16'h0001;
        press(3'b001, 1);
        checks++;
        if (writeAddress !== 10'h001) begin
            errors++;
            $display("FAIL hilo_mask got %h exp 001", writeAddress);
        end
        // Select change after loadLow must not retarget the pending write.
        select = 2'd3;
        switches = 16'h0002;
        press(3'b010, 1);
        q.push_back('{we: 4'b0100, data: 32'h00020001, addr: 10'h001});
        press(3'b100, 1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL hilo_strobe_missing pending=%0d exp 0", q.size());
        end
    endtask

    task automatic test_reg0;
        int s;
        s = strobe_cnt;
        load_word(2'd1, 10'h000, 16'hCAFE, 16'hF00D);
        press(3'b100, 1);
        checks++;
        if (strobe_cnt != s || writeError !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reg0_reject got strobes=%0d err=%b ready=%b exp strobes=%0d err=1 ready=0",
                     strobe_cnt, writeError, ready, s);
        end
        load_word(2'd1, 10'h025, 16'h0A0A, 16'hB0B0);
        q.push_back('{we: 4'b0010, data: 32'hB0B00A0A, addr: 10'h005});
        press(3'b100, 1);
        checks++;
        if (q.size() != 0 || writeError !== 1'b0) begin
            errors++;
            $display("FAIL reg5_write got pending=%0d err=%b exp 0 0", q.size(), writeError);
        end
    endtask

    task automatic test_back_to_back;
        int s;
        load_word(2'd3, 10'h010, 16'hAAAA, 16'h5555);
        q.push_back('{we: 4'b1000, data: 32'h5555AAAA, addr: 10'h010});
        s = strobe_cnt;
        press(3'b100, 50);
        checks++;
        if (strobe_cnt != s + 1 || q.size() != 0) begin
            errors++;
            $display("FAIL held_commit got strobes=%0d pending=%0d exp %0d 0", strobe_cnt, q.size(), s + 1);
        end
        load_word(2'd0, 10'h002, 16'h0F0F, 16'hF0F0);
        s = strobe_cnt;
        switches = 16'h1234;
        press(3'b101, 1);
        checks++;
        if (ready !== 1'b0 || strobe_cnt != s || writeData !== 32'hF0F01234) begin
            errors++;
            $display("FAIL low_beats_commit got ready=%b strobes=%0d data=%h exp 0 %0d f0f01234",
                     ready, strobe_cnt, writeData, s);
        end
        press(3'b100, 1);
        checks++;
        if (strobe_cnt != s) begin
            errors++;
            $display("FAIL lowok_commit_ignored got strobes=%0d exp %0d", strobe_cnt, s);
        end
        switches = 16'h9999;
        press(3'b010, 1);
        q.push_back('{we: 4'b0001, data: 32'h99991234, addr: 10'h002});
        press(3'b100, 1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL b2b_strobe_missing pending=%0d exp 0", q.size());
        end
    endtask

    task automatic test_reset_mid_write;
        bit seen;
        seen = 1'b0;
        load_word(2'd3, 10'h044, 16'h1111, 16'h2222);
        @(negedge clock);
        keyCommit = 1'b1;
        @(negedge clock);
        keyCommit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (memWe === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_write_timeout got no strobe exp memWe=1");
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({instrWe, regWe, hiLoWe, memWe, ready} !== 5'b0 || writeData !== 32'h0) begin
            errors++;
            $display("FAIL mid_write_reset got flags=%b data=%h exp 00000 0",
                     {instrWe, regWe, hiLoWe, memWe, ready}, writeData);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

`ifdef DEBUG_WRITER_AUTOINC_EN
    task automatic test_autoinc;
        load_word(2'd2, 10'h001, 16'h1111, 16'h2222);
        q.push_back('{we: 4'b0100, data: 32'h22221111, addr: 10'h001});
        press(3'b100, 1);
        checks++;
        if (q.size() != 0 || writeAddress !== 10'h000) begin
            errors++;
            $display("FAIL autoinc_hilo got pending=%0d addr=%h exp 0 000", q.size(), writeAddress);
        end
        switches = 16'h3333;
        press(3'b010, 1);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL autoinc_ready got %b exp 1", ready);
        end
        q.push_back('{we: 4'b0100, data: 32'h33331111, addr: 10'h000});
        press(3'b100, 1);
        load_word(2'd1, 10'h01F, 16'h4444, 16'h5555);
        q.push_back('{we: 4'b0010, data: 32'h55554444, addr: 10'h01F});
        press(3'b100, 1);
        checks++;
        if (q.size() != 0 || writeAddress !== 10'h001) begin
            errors++;
            $display("FAIL autoinc_reg_wrap got pending=%0d addr=%h exp 0 001", q.size(), writeAddress);
        end
        switches = 16'h6666;
        press(3'b010, 1);
        q.push_back('{we: 4'b0010, data: 32'h66664444, addr: 10'h001});
        press(3'b100, 1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL autoinc_stream pending=%0d exp 0", q.size());
        end
    endtask
`endif

    initial begin
        test_reset;
        test_idle_ignore;
        test_mem_write;
        test_instr_mask;
        test_reg0;
        test_back_to_back;
        test_reset_mid_write;
`ifdef DEBUG_WRITER_AUTOINC_EN
        test_reset;
        test_autoinc;
`endif
        repeat (4) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d exp 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
